// File: rtl/spi_host_master.sv
// spi_host_master: SPI initiator that shifts an 8-bit opcode to the
// game-core responder and clocks back its 24-bit reply.
module spi_host_master #(
  parameter int CLK_DIV      = 4,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  opcode_in,
  output logic        busy,
  output logic        reply_valid,
  output logic [23:0] reply_out,
  output logic        timeout,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        load,
  input  logic        slave_done
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHOP,
    S_REL,
    S_WAIT,
    S_SHRP,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [4:0]    r_bits;
  logic [TW-1:0] r_wait;
  logic [7:0]    r_op;
  logic [22:0]   r_shift;
  logic [1:0]    r_miso_q;
  logic [1:0]    r_done_q;

  logic w_miso_s;
  logic w_done_s;
  logic w_div_end;

  assign w_miso_s  = r_miso_q[1];
  assign w_done_s  = r_done_q[1];
  assign w_div_end = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_miso_q <= '0;
      r_done_q <= '0;
    end else begin
      r_miso_q <= {r_miso_q[0], miso};
      r_done_q <= {r_done_q[0], slave_done};
    end
  end

  // sck toggles at the end of each CLK_DIV-cycle half period;
  // the current sck level tells which half of a bit we are in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bits      <= '0;
      r_wait      <= '0;
      r_op        <= '0;
      r_shift     <= '0;
      busy        <= 1'b0;
      reply_valid <= 1'b0;
      reply_out   <= '0;
      timeout     <= 1'b0;
      sck         <= 1'b0;
      mosi        <= 1'b0;
      load        <= 1'b0;
    end else begin
      reply_valid <= 1'b0;
      timeout     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= opcode_in;
            busy    <= 1'b1;
            load    <= 1'b1;
            mosi    <= opcode_in[7];
            r_div   <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_bits  <= 5'd7;
            r_state <= S_SHOP;
          end else begin
            r_div <= r_div + DIV_ONE;
          end
        end
        S_SHOP: begin
          if (!w_div_end) begin
            r_div <= r_div + DIV_ONE;
          end else begin
            r_div <= '0;
            sck   <= ~sck;
            if (sck) begin
              if (r_bits == 5'd0) begin
                r_state <= S_REL;
              end else begin
                r_bits <= r_bits - 5'd1;
                mosi   <= r_op[r_bits[2:0] - 3'd1];
              end
            end
          end
        end
        S_REL: begin
          if (w_div_end) begin
            r_div   <= '0;
            load    <= 1'b0;
            mosi    <= 1'b0;
            r_wait  <= '0;
            r_state <= S_WAIT;
          end else begin
            r_div <= r_div + DIV_ONE;
          end
        end
        S_WAIT: begin
          if (w_done_s) begin
            r_div   <= '0;
            r_bits  <= 5'd23;
            r_state <= S_SHRP;
          end else if (r_wait == TMO_LAST) begin
            reply_out   <= '0;
            reply_valid <= 1'b1;
            timeout     <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_wait <= r_wait + TMO_ONE;
          end
        end
        S_SHRP: begin
          if (!w_div_end) begin
            r_div <= r_div + DIV_ONE;
          end else begin
            r_div <= '0;
            sck   <= ~sck;
            if (sck) begin
              r_shift <= {r_shift[21:0], w_miso_s};
              if (r_bits == 5'd0) begin
                reply_out   <= {r_shift, w_miso_s};
                reply_valid <= 1'b1;
                r_state     <= S_DONE;
              end else begin
                r_bits <= r_bits - 5'd1;
              end
            end
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master: directed transactions checked against a
// cycle-timeline model of the initiator and a responder model.
`timescale 1ns/1ps
module tb_spi_host_master;

  localparam int D = 4;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  opcode_in = 8'h00;
  logic        busy;
  logic        reply_valid;
  logic [23:0] reply_out;
  logic        timeout;
  logic        sck;
  logic        mosi;
  logic        miso = 1'b0;
  logic        load;
  logic        slave_done = 1'b0;

  always #5 clk = ~clk;

  spi_host_master #(
    .CLK_DIV(D),
    .DONE_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .opcode_in(opcode_in),
    .busy(busy),
    .reply_valid(reply_valid),
    .reply_out(reply_out),
    .timeout(timeout),
    .sck(sck),
    .mosi(mosi),
    .miso(miso),
    .load(load),
    .slave_done(slave_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;

  logic [23:0] cfg_rep = '0;
  int cfg_d = 0;
  int gen = 0;

  // responder: captures opcode on sck rise, serves reply on sck fall
  int seen_gen = 0;
  int rl = 0, rr = 0, ridx = 0, sl = 0, stab_err = 0;
  logic [7:0] cap = '0;
  logic psck = 1'b0, lhi = 1'b0, mar = 1'b0;

  always @(negedge clk) begin
    if (gen != seen_gen) begin
      seen_gen = gen;
      rl = 0; rr = 0; ridx = 0; sl = 0; stab_err = 0;
      cap = '0; lhi = 1'b0;
      slave_done = 1'b0;
      miso = 1'b0;
    end else begin
      if (load) lhi = 1'b1;
      if (sck && !psck) begin
        if (load) begin
          rl++;
          cap = {cap[6:0], mosi};
          mar = mosi;
        end else begin
          rr++;
          if (rr == 3) slave_done = 1'b0;
        end
      end else if (sck && psck && load && mosi !== mar) begin
        stab_err++;
      end
      if (!sck && psck && !load && rr > 0) begin
        ridx++;
        miso = (ridx < 24) ? cfg_rep[23-ridx] : 1'b0;
      end
      if (!load && lhi && cfg_d > 0 && rr == 0) begin
        sl++;
        if (sl == cfg_d) begin
          slave_done = 1'b1;
          miso = cfg_rep[23];
        end
      end
    end
    psck = sck;
  end

  // timeline model: m_k is the cycle index since start acceptance
  int m_k = 0, m_n = 0, m_w = 0;
  logic m_to = 1'b0;
  logic [7:0] m_op = '0;
  logic [23:0] m_rep = '0, m_hold = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_k = 0;
      m_hold = '0;
    end else if (m_k != 0) begin
      m_k++;
      if (m_k > m_n) m_k = 0;
    end else if (start) begin
      m_k = 1;
      m_op = opcode_in;
      m_to = (cfg_d <= 0) || (cfg_d + 2 > T);
      m_w = m_to ? T : cfg_d + 2;
      m_rep = cfg_rep;
      m_n = m_to ? 18*D + T + 1 : 66*D + m_w + 1;
    end
    if (m_k != 0 && m_k == m_n) m_hold = m_to ? 24'h0 : m_rep;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic monitor();
    logic eb, el, es, em, ev, et;
    logic [23:0] eo;
    int k;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        k = m_k;
        eb = (k != 0);
        el = (k >= 1 && k <= 18*D);
        es = 1'b0;
        if (k >= D+1 && k <= 17*D)
          es = (((k-D-1)/D) % 2) == 1;
        if (!m_to && k >= 18*D+m_w+1 && k <= 66*D+m_w)
          es = (((k-18*D-m_w-1)/D) % 2) == 1;
        em = 1'b0;
        if (k >= 1 && k <= D) em = m_op[7];
        else if (k >= D+1 && k <= 17*D)
          em = m_op[7-((k-D-1)/(2*D))];
        else if (k >= 17*D+1 && k <= 18*D) em = m_op[0];
        ev = (k != 0 && k == m_n);
        et = ev && m_to;
        eo = m_hold;
        n_cmp++;
        if ({busy, load, sck, mosi, reply_valid, timeout, reply_out}
            !== {eb, el, es, em, ev, et, eo}) begin
          n_bad++;
          $display("FAIL cycle k=%0d: got b%b l%b s%b m%b v%b t%b %h, expected b%b l%b s%b m%b v%b t%b %h",
                   k, busy, load, sck, mosi, reply_valid, timeout,
                   reply_out, eb, el, es, em, ev, et, eo);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [7:0] op, input logic [23:0] rep,
                         input int d, input int inj, input int rst_rise,
                         input int exp_lat, input logic [23:0] exp_out,
                         input logic exp_to, input string nm);
    int n, lf;
    cfg_rep = rep;
    cfg_d = d;
    gen++;
    step();
    start = 1'b1;
    opcode_in = op;
    step();
    start = 1'b0;
    n = 1;
    lf = 0;
    while (!reply_valid && n < 2000) begin
      if (lf == 0 && !load) lf = n;
      if (rst_rise > 0 && rr >= rst_rise) break;
      start = (inj > 0 && n == inj);
      if (start) opcode_in = 8'hFF;
      step();
      n++;
    end
    start = 1'b0;
    if (rst_rise > 0) begin
      chk({nm, "_abort_rise"}, rr, rst_rise);
      reset = 1'b1;
      step();
      chk({nm, "_rst_sck"}, sck, 0);
      chk({nm, "_rst_load"}, load, 0);
      chk({nm, "_rst_busy"}, busy, 0);
      chk({nm, "_rst_rv"}, reply_valid, 0);
      reset = 1'b0;
      return;
    end
    chk({nm, "_rv_seen"}, reply_valid, 1);
    chk({nm, "_latency"}, n, exp_lat);
    chk({nm, "_reply"}, reply_out, exp_out);
    chk({nm, "_timeout"}, timeout, exp_to);
    chk({nm, "_opcode"}, cap, op);
    chk({nm, "_rises_load"}, rl, 8);
    chk({nm, "_rises_reply"}, rr, exp_to ? 0 : 24);
    chk({nm, "_mosi_stable"}, stab_err, 0);
    if (exp_to) chk({nm, "_wait"}, n - lf, T);
  endtask

  initial begin
    int bz;
    fork
      monitor();
    join_none
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_load", load, 0);
    chk("rst_rv", reply_valid, 0);
    chk("rst_to", timeout, 0);
    chk("rst_out", reply_out, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    run_txn(8'h1A, 24'h00888D, 3, 0, 0, 270, 24'h00888D, 1'b0, "single");
    run_txn(8'h2F, 24'hA5C3F0, 3, 0, 0, 270, 24'hA5C3F0, 1'b0, "alt");
    run_txn(8'h3C, 24'h777777, 0, 0, 0, 89, 24'h000000, 1'b1, "tmo");
    step();
    chk("tmo_busy_after", busy, 0);

    run_txn(8'h5A, 24'h123456, 3, 30, 0, 270, 24'h123456, 1'b0, "busy_start");
    bz = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy) bz = 1;
    end
    chk("no_second_txn", bz, 0);

    run_txn(8'h77, 24'hABCDEF, 3, 0, 10, 0, 24'h0, 1'b0, "abort");
    run_txn(8'h11, 24'h654321, 3, 0, 0, 270, 24'h654321, 1'b0, "post_abort");
    run_txn(8'h81, 24'hFFFFFF, 3, 0, 0, 270, 24'hFFFFFF, 1'b0, "b2b_ones");
    run_txn(8'h42, 24'h000001, 3, 0, 0, 270, 24'h000001, 1'b0, "b2b_one");
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
